// File: rtl/exp_range_reduce.sv
// Range reduction for exp(x): x = r - n*ln2 with r in (-ln2, 0], plus an in-order n side-band FIFO.
// Optional build macro EXP_RR_STATS_EN adds stat_accepted / stat_underflow counters.
module exp_range_reduce #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] x_in,
  input  logic        x_in_valid,
  output logic        x_in_ready,
  output logic [63:0] r_out,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [5:0]  n_out,
  output logic        n_uf,
  output logic        n_valid,
  input  logic        n_ready
`ifdef EXP_RR_STATS_EN
  ,
  output logic [31:0] stat_accepted,
  output logic [31:0] stat_underflow
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic signed [63:0] LN2     = 64'sd762123384786;
  localparam logic signed [63:0] LN2_NEG = -64'sd762123384786;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [63:0] r_acc;
  logic [2:0]         r_step;
  logic [5:0]         r_n;
  logic [63:0]        r_r_out;
  logic               r_r_valid;

  logic [6:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  logic               w_accept;
  logic               w_finish;
  logic [2:0]         w_j;
  logic signed [63:0] w_ln2_sh;
  logic signed [63:0] w_sum;
  logic               w_take;
  logic               w_uf;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [6:0]         w_push_data;
  logic [6:0]         w_head;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign x_in_ready  = (r_state == IDLE) && !w_full;
  assign w_accept    = x_in_valid && x_in_ready;
  assign w_finish    = (r_state == REDUCE) && (r_step == 3'd6);
  assign w_j         = 3'd5 - r_step;
  assign w_ln2_sh    = LN2 << w_j;
  assign w_sum       = r_acc + w_ln2_sh;
  assign w_take      = (w_sum <= 64'sd0);
  assign w_uf        = (r_acc <= LN2_NEG);
  assign w_push      = w_finish;
  assign w_push_data = w_uf ? {1'b1, 6'd63} : {1'b0, r_n};
  assign w_pop       = n_valid && n_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign r_out   = r_r_out;
  assign r_valid = r_r_valid;
  assign n_valid = !w_empty;
  assign n_out   = w_empty ? 6'd0 : w_head[5:0];
  assign n_uf    = w_empty ? 1'b0 : w_head[6];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = REDUCE;
        else          w_state_nxt = IDLE;
      end
      REDUCE: begin
        if (w_finish) w_state_nxt = OUT;
        else          w_state_nxt = REDUCE;
      end
      OUT: begin
        if (r_r_valid && r_ready) w_state_nxt = IDLE;
        else                      w_state_nxt = OUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Restoring reduction: one n bit per cycle MSB first, then the underflow check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= 64'sd0;
      r_step    <= 3'd0;
      r_n       <= 6'd0;
      r_r_out   <= 64'd0;
      r_r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc  <= ($signed(x_in) > 64'sd0) ? 64'sd0 : $signed(x_in);
            r_step <= 3'd0;
            r_n    <= 6'd0;
          end
        end
        REDUCE: begin
          if (w_finish) begin
            r_r_out   <= w_uf ? 64'd0 : r_acc;
            r_r_valid <= 1'b1;
          end else begin
            if (w_take) begin
              r_acc <= w_sum;
              r_n   <= r_n | (6'd1 << w_j);
            end
            r_step <= r_step + 3'd1;
          end
        end
        OUT: begin
          if (r_ready) r_r_valid <= 1'b0;
        end
        default: begin
          r_r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Side-band FIFO storage; empty entries are masked at the output
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // Side-band FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef EXP_RR_STATS_EN
  logic [31:0] r_stat_acc;
  logic [31:0] r_stat_uf;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_acc <= 32'd0;
      r_stat_uf  <= 32'd0;
    end else begin
      if (w_accept)         r_stat_acc <= r_stat_acc + 32'd1;
      if (w_push && w_uf)   r_stat_uf  <= r_stat_uf + 32'd1;
    end
  end

  assign stat_accepted  = r_stat_acc;
  assign stat_underflow = r_stat_uf;
`endif

endmodule

// File: tb/tb_exp_range_reduce.sv
// Directed self-checking bench for exp_range_reduce.
module tb_exp_range_reduce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] x_in = 64'd0;
  logic        x_in_valid = 1'b0;
  logic        x_in_ready;
  logic [63:0] r_out;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [5:0]  n_out;
  logic        n_uf;
  logic        n_valid;
  logic        n_ready = 1'b0;
`ifdef EXP_RR_STATS_EN
  logic [31:0] stat_accepted;
  logic [31:0] stat_underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] ONE    = 64'd1099511627776;
  localparam logic [63:0] M_ONE  = -64'sd1099511627776;
  localparam logic [63:0] M_FIVE = -64'sd5497558138880;
  localparam logic [63:0] M_50   = -64'sd54975581388800;
  localparam logic [63:0] HALF   = 64'd549755813888;
  localparam logic [63:0] R_M1   = -64'sd337388242990;
  localparam logic [63:0] R_M5   = -64'sd162694445378;

  exp_range_reduce #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_in       (x_in),
    .x_in_valid (x_in_valid),
    .x_in_ready (x_in_ready),
    .r_out      (r_out),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .n_out      (n_out),
    .n_uf       (n_uf),
    .n_valid    (n_valid),
    .n_ready    (n_ready)
`ifdef EXP_RR_STATS_EN
    ,
    .stat_accepted  (stat_accepted),
    .stat_underflow (stat_underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic run_one(input string tag, input logic [63:0] x, input logic [63:0] er,
                         input logic [5:0] en, input logic eu);
    @(negedge clk);
    x_in = x; x_in_valid = 1'b1; r_ready = 1'b0; n_ready = 1'b0;
    check({tag, "_ready"}, {63'd0, x_in_ready}, 64'd1);
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check({tag, "_early_valid"}, {63'd0, r_valid}, 64'd0);
    end
    @(posedge clk); #1;
    check({tag, "_r_valid"}, {63'd0, r_valid}, 64'd1);
    check({tag, "_r_out"}, r_out, er);
    check({tag, "_n_valid"}, {63'd0, n_valid}, 64'd1);
    check({tag, "_n_out"}, {58'd0, n_out}, {58'd0, en});
    check({tag, "_n_uf"}, {63'd0, n_uf}, {63'd0, eu});
    @(negedge clk); r_ready = 1'b1;
    @(posedge clk); #1; r_ready = 1'b0;
    check({tag, "_r_drop"}, {63'd0, r_valid}, 64'd0);
    @(negedge clk); n_ready = 1'b1;
    @(posedge clk); #1; n_ready = 1'b0;
    check({tag, "_n_drop"}, {63'd0, n_valid}, 64'd0);
  endtask

  task automatic send_wait(input logic [63:0] x);
    bit done = 1'b0;
    @(negedge clk);
    x_in = x; x_in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (x_in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    x_in_valid = 1'b0;
    check("send_accept", {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [5:0] exp_n [4];
    exp_n[0] = 6'd1; exp_n[1] = 6'd1; exp_n[2] = 6'd1; exp_n[3] = 6'd7;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("rst_r_out", r_out, 64'd0);
    check("rst_n_valid", {63'd0, n_valid}, 64'd0);
    check("rst_n_out", {58'd0, n_out}, 64'd0);
    check("rst_n_uf", {63'd0, n_uf}, 64'd0);
    check("rst_ready", {63'd0, x_in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;

    // directed values
    run_one("zero", 64'd0, 64'd0, 6'd0, 1'b0);
    run_one("m_one", M_ONE, R_M1, 6'd1, 1'b0);
    run_one("m_five", M_FIVE, R_M5, 6'd7, 1'b0);
    run_one("p_half", HALF, 64'd0, 6'd0, 1'b0);
    run_one("p_one", ONE, 64'd0, 6'd0, 1'b0);
    run_one("m_fifty", M_50, 64'd0, 6'd63, 1'b1);
`ifdef EXP_RR_STATS_EN
    check("stat_accepted", {32'd0, stat_accepted}, 64'd6);
    check("stat_underflow", {32'd0, stat_underflow}, 64'd1);
`endif

    // fill the side-band FIFO while r side drains freely
    r_ready = 1'b1; n_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_wait(M_ONE);
    repeat (9) @(posedge clk);
    #1;
    check("full_n_valid", {63'd0, n_valid}, 64'd1);
    check("full_ready", {63'd0, x_in_ready}, 64'd0);
    @(negedge clk);
    x_in = M_FIVE; x_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("full_blocked", {63'd0, x_in_ready}, 64'd0);
    end
    check("full_head", {58'd0, n_out}, 64'd1);
    @(negedge clk); n_ready = 1'b1;
    @(posedge clk); #1; n_ready = 1'b0;
    check("pop_ready", {63'd0, x_in_ready}, 64'd1);
    @(posedge clk); #1; x_in_valid = 1'b0;
    check("fifth_busy", {63'd0, x_in_ready}, 64'd0);
    repeat (6) @(posedge clk);
    @(posedge clk); #1;
    check("fifth_r_valid", {63'd0, r_valid}, 64'd1);
    check("fifth_r_out", r_out, R_M5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_order", {58'd0, n_out}, {58'd0, exp_n[k]});
      n_ready = 1'b1;
      @(posedge clk); #1; n_ready = 1'b0;
    end
    check("drain_empty", {63'd0, n_valid}, 64'd0);

    // reset during REDUCE with a stale FIFO entry present
    r_ready = 1'b1; n_ready = 1'b0;
    send_wait(M_FIVE);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_entry", {63'd0, n_valid}, 64'd1);
    send_wait(M_ONE);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("mid_rst_n_valid", {63'd0, n_valid}, 64'd0);
    check("mid_rst_n_out", {58'd0, n_out}, 64'd0);
    @(negedge clk); rst_n = 1'b1; r_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {63'd0, x_in_ready}, 64'd1);
    check("post_rst_r_valid", {63'd0, r_valid}, 64'd0);
    run_one("after_rst", M_ONE, R_M1, 6'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
